xor_rate_absorb: RTL and testbench

Parametrised, registered successor to the upstream rate-XOR stage of the Ascon datapath. It accepts one rate block per valid/ready handshake and XORs it into the rate words of the sampled state. It applies Ascon 10* padding on partial final blocks and, depending on mode, produces ciphertext or plaintext, or performs associated-data absorption. It sits between the Ascon controller/input buffer and the permutation, with a one-entry output register that holds the updated state until the downstream permutation accepts it.

---
 rtl/xor_rate_absorb.sv | 118 +++++++++++
 tb/tb_xor_rate_absorb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_rate_absorb.sv
// Registered Ascon rate-XOR/absorb stage with 10* padding and a one-entry output register
// that holds the updated state until the permutation consumes it.
module xor_rate_absorb #(
    parameter int RATE_WORDS = 1,
    localparam int RATE_BYTES = 8 * RATE_WORDS,
    localparam int NB_W = $clog2(RATE_BYTES + 1)
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic [4:0][63:0]          state_i,
    input  logic [64*RATE_WORDS-1:0]  data_i,
    input  logic [NB_W-1:0]           nbytes_i,
    input  logic                      last_i,
    input  logic [1:0]                mode_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [4:0][63:0]          state_o,
    output logic [64*RATE_WORDS-1:0]  data_o,
    output logic                      data_en_o,
    output logic [NB_W-1:0]           nbytes_o,
    output logic                      last_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [15:0]               block_cnt_o
);

    if (RATE_WORDS != 1 && RATE_WORDS != 2) begin : g_bad_rate_words
        $error("xor_rate_absorb: RATE_WORDS must be 1 or 2");
    end

    localparam logic [1:0] MODE_ENC    = 2'b01;
    localparam logic [1:0] MODE_DEC    = 2'b10;
    localparam logic [1:0] MODE_BYPASS = 2'b11;

    typedef enum logic {EMPTY, FULL} fsm_t;

    fsm_t                     fsm;
    logic                     accept;
    logic [NB_W-1:0]          k_eff;
    logic                     data_en_nxt;
    logic [4:0][63:0]         state_nxt;
    logic [64*RATE_WORDS-1:0] data_nxt;
    logic [15:0]              cnt_nxt;
    logic [7:0]               rate_byte [RATE_BYTES];
    logic [7:0]               data_byte [RATE_BYTES];

    assign ready_o     = (fsm == EMPTY) || out_ready_i;
    assign accept      = valid_i && ready_o;
    assign out_valid_o = (fsm == FULL);
    assign data_en_nxt = (mode_i == MODE_ENC) || (mode_i == MODE_DEC);

    // Byte j of the rate is big-endian across the rate words, matching data_i.
    for (genvar j = 0; j < RATE_BYTES; j++) begin : g_bytes
        assign rate_byte[j] = state_i[j/8][63-8*(j%8) -: 8];
        assign data_byte[j] = data_i[8*(RATE_BYTES-j)-1 -: 8];
    end

    always_comb begin
        if (!last_i || (nbytes_i > NB_W'(RATE_BYTES))) begin
            k_eff = NB_W'(RATE_BYTES);
        end else begin
            k_eff = nbytes_i;
        end
    end

    // Padding lands on byte k only when k is inside the rate, so a full final block gets none.
    always_comb begin
        state_nxt = state_i;
        data_nxt  = '0;
        for (int j = 0; j < RATE_BYTES; j++) begin
            if (mode_i != MODE_BYPASS) begin
                if (NB_W'(j) < k_eff) begin
                    state_nxt[j/8][63-8*(j%8) -: 8] = (mode_i == MODE_DEC) ? data_byte[j]
                                                                            : rate_byte[j] ^ data_byte[j];
                end else if (NB_W'(j) == k_eff) begin
                    state_nxt[j/8][63-8*(j%8) -: 8] = rate_byte[j] ^ 8'h80;
                end
            end
            if (data_en_nxt && (NB_W'(j) < k_eff)) begin
                data_nxt[8*(RATE_BYTES-j)-1 -: 8] = rate_byte[j] ^ data_byte[j];
            end
        end
    end

    always_comb begin
        if (last_i) begin
            cnt_nxt = '0;
        end else if (block_cnt_o == 16'hFFFF) begin
            cnt_nxt = block_cnt_o;
        end else begin
            cnt_nxt = block_cnt_o + 16'd1;
        end
    end

    // A consume and an accept in the same cycle reload the register without a bubble.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm         <= EMPTY;
            state_o     <= '0;
            data_o      <= '0;
            data_en_o   <= 1'b0;
            nbytes_o    <= '0;
            last_o      <= 1'b0;
            block_cnt_o <= '0;
        end else if (accept) begin
            fsm         <= FULL;
            state_o     <= state_nxt;
            data_o      <= data_nxt;
            data_en_o   <= data_en_nxt;
            nbytes_o    <= k_eff;
            last_o      <= last_i;
            block_cnt_o <= cnt_nxt;
        end else if (out_ready_i) begin
            fsm <= EMPTY;
        end
    end

endmodule

// File: tb/tb_xor_rate_absorb.sv
// Scoreboard bench for xor_rate_absorb: an Ascon-128 and an Ascon-128a instance share one
// stimulus stream; a byte-string reference model predicts each held block.
module tb_xor_rate_absorb;

    typedef logic [4:0][63:0] st_t;

    typedef struct {
        st_t          st;
        logic [127:0] data;
        logic         den;
        int           nb;
        logic         last;
        logic [15:0]  cnt;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_i = 1'b1;
    logic         valid = 1'b0;
    logic         last = 1'b0;
    logic         out_ready = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [4:0]   nbytes = '0;
    logic [127:0] din = '0;
    st_t          st_in = '0;

    logic         ready1, data_en1, last_o1, out_valid1;
    st_t          state_o1;
    logic [63:0]  data_o1;
    logic [3:0]   nbytes_o1;
    logic [15:0]  cnt1;

    logic         ready2, data_en2, last_o2, out_valid2;
    st_t          state_o2;
    logic [127:0] data_o2;
    logic [4:0]   nbytes_o2;
    logic [15:0]  cnt2;

    int          checks = 0;
    int          errors = 0;
    exp_t        q1[$];
    exp_t        q2[$];
    logic        exp_full = 1'b0;
    logic [15:0] cnt_model = '0;

    xor_rate_absorb #(.RATE_WORDS(1)) dut1 (
        .clock_i(clock), .reset_i(reset_i), .state_i(st_in), .data_i(din[127:64]),
        .nbytes_i(nbytes[3:0]), .last_i(last), .mode_i(mode), .valid_i(valid),
        .ready_o(ready1), .state_o(state_o1), .data_o(data_o1), .data_en_o(data_en1),
        .nbytes_o(nbytes_o1), .last_o(last_o1), .out_valid_o(out_valid1),
        .out_ready_i(out_ready), .block_cnt_o(cnt1)
    );

    xor_rate_absorb #(.RATE_WORDS(2)) dut2 (
        .clock_i(clock), .reset_i(reset_i), .state_i(st_in), .data_i(din),
        .nbytes_i(nbytes), .last_i(last), .mode_i(mode), .valid_i(valid),
        .ready_o(ready2), .state_o(state_o2), .data_o(data_o2), .data_en_o(data_en2),
        .nbytes_o(nbytes_o2), .last_o(last_o2), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .block_cnt_o(cnt2)
    );

    always #5 clock = ~clock;

    task automatic compare(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // The rate is treated as one big-endian byte string {word0, word1}.
    function automatic exp_t model(input int rw, input st_t st, input logic [127:0] dv, input int nb,
                                   input logic lst, input logic [1:0] md, input logic [15:0] cnt);
        exp_t         e;
        logic [127:0] rate_str;
        logic [127:0] new_str;
        logic [127:0] out_str;
        logic [7:0]   r, d;
        int           rb, k;
        rb       = 8 * rw;
        k        = !lst ? rb : ((nb > rb) ? rb : nb);
        rate_str = {st[0], st[1]};
        new_str  = rate_str;
        out_str  = '0;
        for (int j = 0; j < rb; j++) begin
            r = rate_str[127-8*j -: 8];
            d = dv[127-8*j -: 8];
            if (j < k) begin
                case (md)
                    2'b00: new_str[127-8*j -: 8] = r ^ d;
                    2'b01: begin new_str[127-8*j -: 8] = r ^ d; out_str[127-8*j -: 8] = r ^ d; end
                    2'b10: begin new_str[127-8*j -: 8] = d;     out_str[127-8*j -: 8] = r ^ d; end
                    default: ;
                endcase
            end else if (j == k && md != 2'b11) begin
                new_str[127-8*j -: 8] = r ^ 8'h80;
            end
        end
        e.st    = st;
        e.st[0] = new_str[127:64];
        if (rw == 2) e.st[1] = new_str[63:0];
        e.data = out_str;
        e.den  = (md == 2'b01) || (md == 2'b10);
        e.nb   = k;
        e.last = lst;
        e.cnt  = cnt;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input exp_t e, input st_t s, input logic [127:0] d,
                               input logic den, input int nb, input logic l, input logic [15:0] c);
        compare({tag, "_state"},   s, e.st);
        compare({tag, "_data"},    320'(d), 320'(e.data));
        compare({tag, "_data_en"}, 320'(den), 320'(e.den));
        compare({tag, "_nbytes"},  320'(nb), 320'(e.nb));
        compare({tag, "_last"},    320'(l), 320'(e.last));
        compare({tag, "_cnt"},     320'(c), 320'(e.cnt));
    endtask

    // One cycle of stimulus; handshake expectations come from the bench's own occupancy flag.
    task automatic applyStimulus(input logic v, input st_t s, input logic [127:0] d, input logic [4:0] nb,
                                 input logic l, input logic [1:0] m, input logic ordy);
        logic exp_ready;
        @(posedge clock);
        #1;
        valid = v; st_in = s; din = d; nbytes = nb; last = l; mode = m; out_ready = ordy;
        @(negedge clock);
        exp_ready = !exp_full || out_ready;
        compare("ready_1", 320'(ready1), 320'(exp_ready));
        compare("ready_2", 320'(ready2), 320'(exp_ready));
        compare("out_valid_1", 320'(out_valid1), 320'(exp_full));
        compare("out_valid_2", 320'(out_valid2), 320'(exp_full));
        if (valid && exp_ready) begin
            cnt_model = last ? 16'd0 : ((cnt_model == 16'hFFFF) ? cnt_model : cnt_model + 16'd1);
            q1.push_back(model(1, st_in, din, int'(nbytes[3:0]), last, mode, cnt_model));
            q2.push_back(model(2, st_in, din, int'(nbytes), last, mode, cnt_model));
            exp_full = 1'b1;
        end else if (out_ready) begin
            exp_full = 1'b0;
        end
    endtask

    task automatic doReset();
        @(posedge clock);
        #1;
        reset_i = 1'b1; valid = 1'b1; out_ready = 1'b0;
        exp_full = 1'b0; cnt_model = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        compare("rst_out_valid_1", 320'(out_valid1), 320'(0));
        compare("rst_out_valid_2", 320'(out_valid2), 320'(0));
        compare("rst_state_1", state_o1, 320'(0));
        compare("rst_state_2", state_o2, 320'(0));
        compare("rst_data_1", 320'(data_o1), 320'(0));
        compare("rst_data_2", 320'(data_o2), 320'(0));
        compare("rst_misc_1", 320'({data_en1, nbytes_o1, last_o1, cnt1}), 320'(0));
        compare("rst_misc_2", 320'({data_en2, nbytes_o2, last_o2, cnt2}), 320'(0));
        @(posedge clock);
        #1;
        reset_i = 1'b0; valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (reset_i) begin
            q1.delete();
            q2.delete();
        end else begin
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL dut1_unexpected_out actual=valid required=empty");
                end else begin
                    checkOutput("dut1", q1[0], state_o1, {data_o1, 64'h0}, data_en1, int'(nbytes_o1), last_o1, cnt1);
                    if (out_ready) void'(q1.pop_front());
                end
            end
            if (out_valid2) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL dut2_unexpected_out actual=valid required=empty");
                end else begin
                    checkOutput("dut2", q2[0], state_o2, data_o2, data_en2, int'(nbytes_o2), last_o2, cnt2);
                    if (out_ready) void'(q2.pop_front());
                end
            end
        end
    end

    initial begin
        st_t          s;
        logic [127:0] d;
        doReset();

        s = '{64'h5, 64'h4, 64'h3, 64'h2, 64'h0123456789ABCDEF};
        applyStimulus(1'b1, s, {2{64'hFFFFFFFFFFFFFFFF}}, 5'd0, 1'b0, 2'b01, 1'b1);
        applyStimulus(1'b0, s, '0, 5'd0, 1'b0, 2'b00, 1'b0);
        compare("plan_enc_state0", 320'(state_o1[0]), 320'(64'hFEDCBA9876543210));
        compare("plan_enc_data", 320'(data_o1), 320'(64'hFEDCBA9876543210));
        compare("plan_enc_cap", 320'(state_o1[4:1]), 320'({64'h5, 64'h4, 64'h3, 64'h2}));
        compare("plan_enc_cnt", 320'(cnt1), 320'(1));

        s = '0;
        applyStimulus(1'b1, s, {64'hAABBCCDDEEFF0011, 64'h0}, 5'd3, 1'b1, 2'b01, 1'b1);
        applyStimulus(1'b0, s, '0, 5'd0, 1'b0, 2'b00, 1'b0);
        compare("plan_part_data", 320'(data_o1), 320'(64'hAABBCC0000000000));
        compare("plan_part_state0", 320'(state_o1[0]), 320'(64'hAABBCC8000000000));
        compare("plan_part_cnt", 320'(cnt1), 320'(0));

        s = '{64'h0, 64'h0, 64'h0, 64'h1111111111111111, 64'h1111111111111111};
        applyStimulus(1'b1, s, {16{8'h22}}, 5'd9, 1'b1, 2'b10, 1'b1);
        applyStimulus(1'b0, s, '0, 5'd0, 1'b0, 2'b00, 1'b0);
        compare("plan_dec_data", 320'(data_o2), 320'({64'h3333333333333333, 64'h3300000000000000}));
        compare("plan_dec_state", 320'({state_o2[0], state_o2[1]}),
                320'({64'h2222222222222222, 64'h2291111111111111}));

        s = '0;
        applyStimulus(1'b1, s, {2{64'h0123456789ABCDEF}}, 5'd0, 1'b1, 2'b00, 1'b1);
        applyStimulus(1'b0, s, '0, 5'd0, 1'b0, 2'b00, 1'b0);
        compare("plan_ad_state0", 320'(state_o1[0]), 320'(64'h8000000000000000));
        compare("plan_ad_data_en", 320'(data_en1), 320'(0));

        // Backpressure with changing inputs, then a same-cycle replace, then reset while full.
        for (int i = 0; i < 3; i++) begin
            s = '{$urandom, $urandom, $urandom, {$urandom, $urandom}, {$urandom, $urandom}};
            d = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'b1, s, d, 5'($urandom_range(0, 17)), 1'($urandom), 2'($urandom), 1'b0);
        end
        applyStimulus(1'b1, s, ~d, 5'd5, 1'b1, 2'b01, 1'b1);
        applyStimulus(1'b1, s, d, 5'd2, 1'b0, 2'b10, 1'b0);
        doReset();

        for (int i = 0; i < 400; i++) begin
            s = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}};
            d = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 3) != 0), s, d, 5'($urandom_range(0, 17)),
                          1'($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom_range(0, 9) < 7));
        end

        repeat (3) applyStimulus(1'b0, '0, '0, 5'd0, 1'b0, 2'b00, 1'b1);
        compare("drain_q1", 320'(q1.size()), 320'(0));
        compare("drain_q2", 320'(q2.size()), 320'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
